mem_access_ctrl: RTL and testbench

//  Sequencer between the core load/store stage and the 32-bit word-addressed data memory.

---
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer for a 32-bit word-addressed memory,
// with read-modify-write for sub-word stores. Define SIGN_EXT_EN to add req_signed (sub-word sign extension).

// One byte lane of the store merge: picks the store byte or keeps the byte read back from memory.
module mem_access_lane #(
   parameter int LANE = 0
) (
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [7:0]  rd_byte,
   input  logic [15:0] wdata,
   output logic [7:0]  merged
);
   localparam logic [1:0] LN = LANE[1:0];

   logic       sel;
   logic [7:0] wr_byte;

   always_comb begin
      sel     = 1'b0;
      wr_byte = wdata[7:0];
      case (size)
         2'd0: sel = (addr_lo == LN);
         2'd1: begin
            sel     = (addr_lo[1] == LN[1]);
            wr_byte = LN[0] ? wdata[15:8] : wdata[7:0];
         end
         default: sel = 1'b0;
      endcase
      merged = sel ? wr_byte : rd_byte;
   end
endmodule

module mem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
`ifdef SIGN_EXT_EN
   input  logic              req_signed,
`endif
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD      = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_WR      = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic [1:0]  addr_lo;
      logic        sgn;
      logic [15:0] wdata;
   } req_t;

   logic [2:0] state;
   req_t       req_q;
   logic [3:0] cnt;
   logic       sgn_in;
   logic       req_err;

   logic [NUM_LANES-1:0][VEC_W-1:0] merged_word;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_data;

`ifdef SIGN_EXT_EN
   assign sgn_in = req_signed;
`else
   assign sgn_in = 1'b0;
`endif

   assign req_err = (req_size == 2'd3) ||
                    (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'b00);

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_RESP);
   assign mem_en     = (state == S_RD) || (state == S_WR);
   assign mem_we     = (state == S_WR);

   // Merge runs on the live read data; only captured in the last RD_WAIT cycle.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      mem_access_lane #(.LANE(g)) u_lane (
         .size    (req_q.size),
         .addr_lo (req_q.addr_lo),
         .rd_byte (mem_rdata[VEC_W*g +: VEC_W]),
         .wdata   (req_q.wdata),
         .merged  (merged_word[g])
      );
   end

   always_comb begin
      sel_byte  = mem_rdata[{req_q.addr_lo, 3'b000} +: 8];
      sel_half  = mem_rdata[{req_q.addr_lo[1], 4'b0000} +: 16];
      load_data = mem_rdata;
      case (req_q.size)
         2'd0:    load_data = {{24{req_q.sgn & sel_byte[7]}}, sel_byte};
         2'd1:    load_data = {{16{req_q.sgn & sel_half[15]}}, sel_half};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         req_q      <= '0;
         cnt        <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               req_q.write   <= req_write;
               req_q.size    <= req_size;
               req_q.addr_lo <= req_addr[1:0];
               req_q.sgn     <= sgn_in;
               req_q.wdata   <= req_wdata[15:0];
               mem_addr      <= req_addr[ADDR_W-1:2];
               if (req_err) begin
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
                  state      <= S_RESP;
               end else if (req_write && req_size == 2'd2) begin
                  mem_wdata <= req_wdata;
                  state     <= S_WR;
               end else begin
                  state <= S_RD;
               end
            end
            S_RD: begin
               cnt   <= 4'(MEM_LAT);
               state <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  if (req_q.write) begin
                     mem_wdata <= merged_word;
                     state     <= S_WR;
                  end else begin
                     resp_rdata <= load_data;
                     resp_err   <= 1'b0;
                     state      <= S_RESP;
                  end
               end
            end
            S_WR: begin
               resp_rdata <= '0;
               resp_err   <= 1'b0;
               state      <= S_RESP;
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: MEM_LAT=1 instance plus a MEM_LAT=3 instance.
module tb_mem_access_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, mem_en, mem_we;
   logic [31:0] resp_rdata, mem_wdata, mem_rdata;
   logic [29:0] mem_addr;

   logic        req_valid3 = 1'b0, req_write3 = 1'b0, req_signed3 = 1'b0;
   logic [1:0]  req_size3 = 2'd0;
   logic [31:0] req_addr3 = '0, req_wdata3 = '0;
   logic        req_ready3, resp_valid3, resp_err3, mem_en3, mem_we3;
   logic [31:0] resp_rdata3, mem_wdata3, mem_rdata3;
   logic [29:0] mem_addr3;

   mem_access_ctrl #(.ADDR_W(32), .MEM_LAT(1)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SIGN_EXT_EN
      .req_signed(req_signed),
`endif
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_access_ctrl #(.ADDR_W(32), .MEM_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_write(req_write3), .req_size(req_size3), .req_addr(req_addr3), .req_wdata(req_wdata3),
`ifdef SIGN_EXT_EN
      .req_signed(req_signed3),
`endif
      .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_rdata(mem_rdata3)
   );

   // Memory model: read data is only valid in the exact latency cycle, junk otherwise.
   logic [31:0]      mem [0:255];
   logic             mem_init = 1'b1;
   logic [31:0]      rd_q = 32'h0BAD_F00D;
   logic [2:0][31:0] p3 = '0;
   assign mem_rdata  = rd_q;
   assign mem_rdata3 = p3[2];

   always @(posedge clk) begin
      if (mem_init) begin
         mem[64] <= 32'hA1B2_C3D4;
         mem[65] <= 32'h0000_0000;
      end else if (mem_en && mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
      rd_q <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 32'h0BAD_F00D;
      p3   <= {p3[1], p3[0], (mem_en3 && !mem_we3) ? mem[mem_addr3[7:0]] : 32'h0BAD_F00D};
   end

   int en_cnt = 0, rd_cnt = 0, wr_cnt = 0, wr_cyc = -1;
   always @(negedge clk) begin
      if (mem_en) en_cnt <= en_cnt + 1;
      if (mem_en && !mem_we) rd_cnt <= rd_cnt + 1;
      if (mem_en && mem_we) begin
         wr_cnt <= wr_cnt + 1;
         wr_cyc <= cyc;
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;
   exp_t sb[$];

   int n_chk = 0, n_pass = 0;

   // Presents a request, waits (bounded) until accepted, records the expected response.
   task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic sg,
                       input logic [31:0] e_rd, input logic e_err, input int e_lat);
      exp_t e;
      req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd; req_signed = sg;
      req_valid = 1'b1;
      e.acc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (req_ready) begin
            e.acc = cyc + 1;
            break;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      e.rdata = e_rd; e.err = e_err; e.lat = e_lat;
      sb.push_back(e);
   endtask

   task automatic wait_resp(output int rc, output logic [31:0] rd, output logic er);
      rc = -1; rd = '0; er = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            rc = cyc; rd = resp_rdata; er = resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
      n_chk++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
      n_chk++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else n_pass++;
      n_chk++; if (resp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", resp_err); else n_pass++;
      n_chk++; if ({mem_en, mem_we} !== 2'b00) $display("FAIL reset_mem_en_we: got %b want 00", {mem_en, mem_we}); else n_pass++;
      n_chk++; if (mem_addr !== 30'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
      n_chk++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
      mem_init = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_load();
      logic [31:0] ta [6] = '{32'h102, 32'h102, 32'h100, 32'h103, 32'h100, 32'h100};
      logic [1:0]  ts [6] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
      logic [31:0] te [6] = '{32'h0000_00B2, 32'h0000_A1B2, 32'h0000_00D4,
                              32'h0000_00A1, 32'h0000_C3D4, 32'hA1B2_C3D4};
      int rc; logic [31:0] rd; logic er; exp_t e;
      int rd0 = rd_cnt;
      for (int i = 0; i < 6; i++) begin
         send(1'b0, ts[i], ta[i], 32'hFFFF_FFFF, 1'b0, te[i], 1'b0, 3);
         wait_resp(rc, rd, er);
         e = sb.pop_front();
         n_chk++; if (rd !== e.rdata) $display("FAIL load%0d_rdata: got %h want %h", i, rd, e.rdata); else n_pass++;
         n_chk++; if (er !== e.err) $display("FAIL load%0d_err: got %b want %b", i, er, e.err); else n_pass++;
         n_chk++; if (rc - e.acc + 1 !== e.lat) $display("FAIL load%0d_latency: got %0d want %0d", i, rc - e.acc + 1, e.lat); else n_pass++;
      end
      n_chk++; if (rd_cnt - rd0 !== 6) $display("FAIL load_read_count: got %0d want 6", rd_cnt - rd0); else n_pass++;
   endtask

   task automatic test_store();
      int rc; logic [31:0] rd; logic er; exp_t e;
      int rd0, wr0;
      rd0 = rd_cnt; wr0 = wr_cnt;
      send(1'b1, 2'd0, 32'h101, 32'h0000_005E, 1'b0, 32'h0, 1'b0, 4);
      wait_resp(rc, rd, er);
      e = sb.pop_front();
      n_chk++; if (rc - e.acc + 1 !== e.lat) $display("FAIL sb_latency: got %0d want %0d", rc - e.acc + 1, e.lat); else n_pass++;
      n_chk++; if ({er, rd} !== {e.err, e.rdata}) $display("FAIL sb_resp: got %b/%h want %b/%h", er, rd, e.err, e.rdata); else n_pass++;
      n_chk++; if (mem[64] !== 32'hA1B2_5ED4) $display("FAIL sb_merge: got %h want a1b25ed4", mem[64]); else n_pass++;
      n_chk++; if ({rd_cnt - rd0, wr_cnt - wr0} !== {32'd1, 32'd1}) $display("FAIL sb_rd_wr: got %0d/%0d want 1/1", rd_cnt - rd0, wr_cnt - wr0); else n_pass++;

      rd0 = rd_cnt; wr0 = wr_cnt;
      send(1'b1, 2'd2, 32'h104, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 2);
      wait_resp(rc, rd, er);
      e = sb.pop_front();
      n_chk++; if (rc - e.acc + 1 !== e.lat) $display("FAIL sw_latency: got %0d want %0d", rc - e.acc + 1, e.lat); else n_pass++;
      n_chk++; if (wr_cyc !== e.acc) $display("FAIL sw_write_cycle: got %0d want %0d", wr_cyc, e.acc); else n_pass++;
      n_chk++; if (mem[65] !== 32'hDEAD_BEEF) $display("FAIL sw_data: got %h want deadbeef", mem[65]); else n_pass++;
      n_chk++; if ({rd_cnt - rd0, wr_cnt - wr0} !== {32'd0, 32'd1}) $display("FAIL sw_rd_wr: got %0d/%0d want 0/1", rd_cnt - rd0, wr_cnt - wr0); else n_pass++;

      send(1'b1, 2'd1, 32'h106, 32'hFFFF_1234, 1'b0, 32'h0, 1'b0, 4);
      wait_resp(rc, rd, er);
      e = sb.pop_front();
      n_chk++; if (rc - e.acc + 1 !== e.lat) $display("FAIL sh_latency: got %0d want %0d", rc - e.acc + 1, e.lat); else n_pass++;
      n_chk++; if (mem[65] !== 32'h1234_BEEF) $display("FAIL sh_merge: got %h want 1234beef", mem[65]); else n_pass++;
   endtask

   task automatic test_error();
      logic        tw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [1:0]  ts [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd1};
      logic [31:0] ta [5] = '{32'h103, 32'h102, 32'h100, 32'h100, 32'h101};
      int rc; logic [31:0] rd; logic er; exp_t e;
      int en0 = en_cnt;
      for (int i = 0; i < 5; i++) begin
         send(tw[i], ts[i], ta[i], 32'h1111_1111, 1'b0, 32'h0, 1'b1, 1);
         wait_resp(rc, rd, er);
         e = sb.pop_front();
         n_chk++; if (er !== e.err) $display("FAIL err%0d_flag: got %b want %b", i, er, e.err); else n_pass++;
         n_chk++; if (rd !== e.rdata) $display("FAIL err%0d_rdata: got %h want %h", i, rd, e.rdata); else n_pass++;
         n_chk++; if (rc - e.acc + 1 !== e.lat) $display("FAIL err%0d_latency: got %0d want %0d", i, rc - e.acc + 1, e.lat); else n_pass++;
      end
      n_chk++; if (en_cnt - en0 !== 0) $display("FAIL err_mem_en: got %0d strobes want 0", en_cnt - en0); else n_pass++;
      n_chk++; if (mem[64] !== 32'hA1B2_5ED4) $display("FAIL err_mem_intact: got %h want a1b25ed4", mem[64]); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int a_rc, b_rc; logic [31:0] a_rd, b_rd; logic a_er, b_er; exp_t ea, eb;
      send(1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 32'hA1B2_5ED4, 1'b0, 3);
      // Second request held valid while the first is in flight.
      fork
         send(1'b0, 2'd0, 32'h103, 32'h0, 1'b0, 32'h0000_00A1, 1'b0, 3);
         wait_resp(a_rc, a_rd, a_er);
      join
      wait_resp(b_rc, b_rd, b_er);
      ea = sb.pop_front();
      eb = sb.pop_front();
      n_chk++; if (a_rd !== ea.rdata) $display("FAIL b2b_a_rdata: got %h want %h", a_rd, ea.rdata); else n_pass++;
      n_chk++; if (a_rc - ea.acc + 1 !== ea.lat) $display("FAIL b2b_a_latency: got %0d want %0d", a_rc - ea.acc + 1, ea.lat); else n_pass++;
      n_chk++; if (eb.acc !== a_rc + 2) $display("FAIL b2b_b_accept: got %0d want %0d", eb.acc, a_rc + 2); else n_pass++;
      n_chk++; if (b_rd !== eb.rdata) $display("FAIL b2b_b_rdata: got %h want %h", b_rd, eb.rdata); else n_pass++;
      n_chk++; if (b_rc - eb.acc + 1 !== eb.lat) $display("FAIL b2b_b_latency: got %0d want %0d", b_rc - eb.acc + 1, eb.lat); else n_pass++;
   endtask

   task automatic test_reset_midop();
      exp_t e;
      int wr0;
      send(1'b1, 2'd0, 32'h100, 32'h0000_00AA, 1'b0, 32'h0, 1'b0, 4);
      @(posedge clk); #1;
      wr0 = wr_cnt;
      rst = 1'b1;
      #1;
      n_chk++; if ({req_ready, resp_valid, mem_en, mem_we} !== 4'b1000) $display("FAIL rst_mid_ctrl: got %b want 1000", {req_ready, resp_valid, mem_en, mem_we}); else n_pass++;
      n_chk++; if ({resp_rdata, resp_err} !== 33'h0) $display("FAIL rst_mid_resp: got %h/%b want 0/0", resp_rdata, resp_err); else n_pass++;
      n_chk++; if ({mem_addr, mem_wdata} !== 62'h0) $display("FAIL rst_mid_mem: got %h/%h want 0/0", mem_addr, mem_wdata); else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      e = sb.pop_front();
      n_chk++; if (wr_cnt - wr0 !== 0) $display("FAIL rst_mid_no_write: got %0d writes want 0 (acc %0d)", wr_cnt - wr0, e.acc); else n_pass++;
      n_chk++; if (mem[64] !== 32'hA1B2_5ED4) $display("FAIL rst_mid_mem_intact: got %h want a1b25ed4", mem[64]); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_latency3();
      exp_t e;
      int rc = -1;
      logic [31:0] rd = '0;
      logic er = 1'b0;
      req_write3 = 1'b0; req_size3 = 2'd0; req_addr3 = 32'h102; req_wdata3 = '0; req_signed3 = 1'b0;
      req_valid3 = 1'b1;
      e.acc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (req_ready3) begin
            e.acc = cyc + 1;
            break;
         end
      end
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      e.rdata = 32'h0000_00B2; e.err = 1'b0; e.lat = 5;
      sb.push_back(e);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (resp_valid3) begin
            rc = cyc; rd = resp_rdata3; er = resp_err3;
            break;
         end
      end
      e = sb.pop_front();
      n_chk++; if (rc - e.acc + 1 !== e.lat) $display("FAIL lat3_latency: got %0d want %0d", rc - e.acc + 1, e.lat); else n_pass++;
      n_chk++; if ({er, rd} !== {e.err, e.rdata}) $display("FAIL lat3_resp: got %b/%h want %b/%h", er, rd, e.err, e.rdata); else n_pass++;
   endtask

`ifdef SIGN_EXT_EN
   task automatic test_sign_ext();
      logic [31:0] ta [5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h102};
      logic [1:0]  ts [5] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd1};
      logic        tg [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] te [5] = '{32'hFFFF_A1B2, 32'h0000_005E, 32'hFFFF_FFD4, 32'hA1B2_5ED4, 32'h0000_A1B2};
      int rc; logic [31:0] rd; logic er; exp_t e;
      for (int i = 0; i < 5; i++) begin
         send(1'b0, ts[i], ta[i], 32'h0, tg[i], te[i], 1'b0, 3);
         wait_resp(rc, rd, er);
         e = sb.pop_front();
         n_chk++; if (rd !== e.rdata) $display("FAIL sext%0d_rdata: got %h want %h", i, rd, e.rdata); else n_pass++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_store();
      test_error();
      test_back_to_back();
      test_reset_midop();
      test_latency3();
`ifdef SIGN_EXT_EN
      test_sign_ext();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
